// File: rtl/inc16_sched_pkg.sv
// Shared constants for the inc16 round-robin scheduler.
// Channel indices, channel count and datapath width.
package inc16_sched_pkg;

    localparam int unsigned CH0 = 0;
    localparam int unsigned CH1 = 1;
    localparam int unsigned NCH = 2;
    localparam int unsigned W   = 16;

    // Index of the channel left waiting after a one-hot grant.
    function automatic logic other_ch(input logic [NCH-1:0] g);
        return g[CH0];
    endfunction

endpackage

// File: rtl/inc16.sv
// 16-bit incrementer: sum = a + 1, cout flags the FFFF -> 0000 wrap.
module inc16
    import inc16_sched_pkg::*;
(
    input  logic [W-1:0] a,
    output logic [W-1:0] sum,
    output logic         cout
);

    assign {cout, sum} = {1'b0, a} + {{W{1'b0}}, 1'b1};

endmodule

// File: rtl/inc16_sched.sv
// Two counter channels sharing one inc16, arbitrated round-robin.
// Loads take precedence over increments; wrap flags are sticky until cleared or loaded.
module inc16_sched
    import inc16_sched_pkg::*;
#(
    parameter logic [W-1:0] RST_VAL  = '0,
    parameter logic         PTR_INIT = 1'b0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [NCH-1:0] req,
    input  logic [NCH-1:0] load,
    input  logic [W-1:0]   load_val0,
    input  logic [W-1:0]   load_val1,
    input  logic [NCH-1:0] clr_ovf,
    output logic [NCH-1:0] gnt,
    output logic [W-1:0]   cnt0,
    output logic [W-1:0]   cnt1,
    output logic [NCH-1:0] ovf,
    output logic           ptr
);

    logic [NCH-1:0] elig;
    logic [W-1:0]   inc_a;
    logic [W-1:0]   inc_sum;
    logic           inc_cout;

    assign elig = req & ~load;

    always_comb begin
        gnt = '0;
        if (!reset) begin
            unique case (elig)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = ptr ? 2'b10 : 2'b01;
                default: gnt = '0;
            endcase
        end
    end

    assign inc_a = gnt[CH1] ? cnt1 : cnt0;

    inc16 u_inc16 (
        .a    (inc_a),
        .sum  (inc_sum),
        .cout (inc_cout)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt0 <= RST_VAL;
            cnt1 <= RST_VAL;
            ovf  <= '0;
            ptr  <= PTR_INIT;
        end else begin
            if (load[CH0]) begin
                cnt0 <= load_val0;
            end else if (gnt[CH0]) begin
                cnt0 <= inc_sum;
            end

            if (load[CH1]) begin
                cnt1 <= load_val1;
            end else if (gnt[CH1]) begin
                cnt1 <= inc_sum;
            end

            // A wrap on the same edge beats clr_ovf; a load always clears.
            for (int i = 0; i < NCH; i++) begin
                if (load[i]) begin
                    ovf[i] <= 1'b0;
                end else if (gnt[i] && inc_cout) begin
                    ovf[i] <= 1'b1;
                end else if (clr_ovf[i]) begin
                    ovf[i] <= 1'b0;
                end
            end

            if (gnt != '0) begin
                ptr <= other_ch(gnt);
            end
        end
    end

endmodule

// File: tb/tb_inc16_sched.sv
// Directed bench for inc16_sched with hand-computed expected values.
module tb_inc16_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [1:0]  load;
    logic [15:0] load_val0;
    logic [15:0] load_val1;
    logic [1:0]  clr_ovf;
    logic [1:0]  gnt;
    logic [15:0] cnt0;
    logic [15:0] cnt1;
    logic [1:0]  ovf;
    logic        ptr;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    inc16_sched dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .load      (load),
        .load_val0 (load_val0),
        .load_val1 (load_val1),
        .clr_ovf   (clr_ovf),
        .gnt       (gnt),
        .cnt0      (cnt0),
        .cnt1      (cnt1),
        .ovf       (ovf),
        .ptr       (ptr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Apply inputs, check combinational grant, clock once, check registered state.
    task automatic step(input string tag, input logic rst, input logic [1:0] r,
                        input logic [1:0] ld, input logic [15:0] v0, input logic [15:0] v1,
                        input logic [1:0] clr, input logic [1:0] e_gnt,
                        input logic [15:0] e_cnt0, input logic [15:0] e_cnt1,
                        input logic [1:0] e_ovf, input logic e_ptr);
        reset = rst; req = r; load = ld; load_val0 = v0; load_val1 = v1; clr_ovf = clr;
        #1;
        check({tag, ".gnt"}, 32'(gnt), 32'(e_gnt));
        @(posedge clk);
        #1;
        check({tag, ".cnt0"}, 32'(cnt0), 32'(e_cnt0));
        check({tag, ".cnt1"}, 32'(cnt1), 32'(e_cnt1));
        check({tag, ".ovf"}, 32'(ovf), 32'(e_ovf));
        check({tag, ".ptr"}, 32'(ptr), 32'(e_ptr));
    endtask

    initial begin
        // reset with everything asserted
        step("rst0", 1, 2'b11, 2'b11, 16'h1111, 16'h2222, 2'b00, 2'b00, 16'h0000, 16'h0000, 2'b00, 0);
        step("rst1", 1, 2'b11, 2'b11, 16'h1111, 16'h2222, 2'b00, 2'b00, 16'h0000, 16'h0000, 2'b00, 0);

        // contention alternates
        step("cont0", 0, 2'b11, 2'b00, 0, 0, 2'b00, 2'b01, 16'h0001, 16'h0000, 2'b00, 1);
        step("cont1", 0, 2'b11, 2'b00, 0, 0, 2'b00, 2'b10, 16'h0001, 16'h0001, 2'b00, 0);
        step("cont2", 0, 2'b11, 2'b00, 0, 0, 2'b00, 2'b01, 16'h0002, 16'h0001, 2'b00, 1);
        step("cont3", 0, 2'b11, 2'b00, 0, 0, 2'b00, 2'b10, 16'h0002, 16'h0002, 2'b00, 0);

        // single requester from reset
        step("rst2", 1, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 16'h0000, 16'h0000, 2'b00, 0);
        step("one0", 0, 2'b01, 2'b00, 0, 0, 2'b00, 2'b01, 16'h0001, 16'h0000, 2'b00, 1);
        step("one1", 0, 2'b01, 2'b00, 0, 0, 2'b00, 2'b01, 16'h0002, 16'h0000, 2'b00, 1);
        step("one2", 0, 2'b01, 2'b00, 0, 0, 2'b00, 2'b01, 16'h0003, 16'h0000, 2'b00, 1);

        // wrap on ch1, sticky flag, then clear
        step("wld", 0, 2'b00, 2'b10, 0, 16'hFFFE, 2'b00, 2'b00, 16'h0003, 16'hFFFE, 2'b00, 1);
        step("wr0", 0, 2'b10, 2'b00, 0, 0, 2'b00, 2'b10, 16'h0003, 16'hFFFF, 2'b00, 0);
        step("wr1", 0, 2'b10, 2'b00, 0, 0, 2'b00, 2'b10, 16'h0003, 16'h0000, 2'b10, 0);
        step("whold", 0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 16'h0003, 16'h0000, 2'b10, 0);
        step("wclr", 0, 2'b00, 2'b00, 0, 0, 2'b10, 2'b00, 16'h0003, 16'h0000, 2'b00, 0);

        // load removes ch0 from arbitration
        step("lv0", 0, 2'b00, 2'b01, 16'h0005, 0, 2'b00, 2'b00, 16'h0005, 16'h0000, 2'b00, 0);
        step("lvr", 0, 2'b11, 2'b01, 16'h1234, 0, 2'b00, 2'b10, 16'h1234, 16'h0001, 2'b00, 0);

        // wrap set beats clear on the same edge
        step("sbc0", 0, 2'b00, 2'b01, 16'hFFFF, 0, 2'b00, 2'b00, 16'hFFFF, 16'h0001, 2'b00, 0);
        step("sbc1", 0, 2'b01, 2'b00, 0, 0, 2'b01, 2'b01, 16'h0000, 16'h0001, 2'b01, 1);

        // double load: no grant, pointer holds, load+clr leaves flag clear
        step("dld", 0, 2'b11, 2'b11, 16'hAAAA, 16'h5555, 2'b01, 2'b00, 16'hAAAA, 16'h5555, 2'b00, 1);
        step("inc1", 0, 2'b11, 2'b00, 0, 0, 2'b00, 2'b10, 16'hAAAA, 16'h5556, 2'b00, 0);

        // mid-run reset with requests pending
        step("mrst", 1, 2'b11, 2'b00, 0, 0, 2'b00, 2'b00, 16'h0000, 16'h0000, 2'b00, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/inc16_sched.md
Name: inc16_sched

Overview:
- Round-robin scheduler that shares one inc16 incrementer between two 16-bit counter channels (ch0, ch1).
- Each channel holds a count register that can be incremented on request or loaded directly.
- The shared incrementer serves at most one channel per cycle. The scheduler decides which, and records wrap-around per channel.
- Sits next to the existing inc16 datapath. Serves as a shared program-counter/timer sequencer.

Parameters:
- RST_VAL, 16'h0000, value loaded into both count registers on reset.
- PTR_INIT, 1'b0, round-robin pointer value after reset (0 = ch0 favoured).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  2  increment request, bit i = channel i; level-sensitive, held until granted.
- load  input  2  load strobe, bit i = channel i.
- load_val0  input  16  value loaded into ch0 when load[0]=1.
- load_val1  input  16  value loaded into ch1 when load[1]=1.
- clr_ovf  input  2  clears the sticky wrap flag of channel i.
- gnt  output  2  combinational one-hot grant; at most one bit set; the granted channel increments at the next edge.
- cnt0  output  16  ch0 count register.
- cnt1  output  16  ch1 count register.
- ovf  output  2  sticky wrap flag per channel.
- ptr  output  1  current round-robin pointer, for debug and verification.

Behaviour:
- Reset is synchronous and active-high.
  - At a clk edge with reset=1: cnt0=cnt1=RST_VAL, ovf=2'b00, ptr=PTR_INIT.
  - gnt is forced to 2'b00 whenever reset=1.
  - Reset overrides all other inputs, including mid-request.
- Eligibility: channel i is eligible when req[i]=1 and load[i]=0. A load removes the channel from arbitration that cycle.
- Grant, combinational in the same cycle:
  - No eligible channel: gnt=00.
  - One eligible channel: grant it.
  - Both eligible: grant channel ptr.
- Shared datapath:
  - A single inc16 instance. Its A input is muxed: cnt1 if gnt[1], else cnt0.
  - Its Sum and Cout are used only for the granted channel.
- Edge update for channel i, highest priority first:
  - reset.
  - load[i]: cnt_i <= load_val_i and ovf[i] <= 0. Load also clears ovf.
  - gnt[i]: cnt_i <= Sum, and ovf[i] <= 1 if Cout=1.
  - Otherwise cnt_i holds.
- clr_ovf[i]:
  - Clears ovf[i] at the edge unless the same edge sets it (gnt[i] with Cout=1). Set wins.
  - Load and clr together: flag = 0.
- Wrap: FFFF+1 gives 0000 with Cout=1. Sum is 16 bits only; no saturation.
- Pointer: on any edge where gnt!=00, ptr <= index of the non-granted channel. Otherwise ptr holds.
  - This gives strict alternation under continuous contention.
  - Worst-case wait for a requesting channel is 1 cycle.
- Loads on both channels in the same cycle: both load, gnt=00, ptr holds.
- Latency: count visible on cnt* one cycle after the grant or load cycle. No internal pipelining.
- A request held high after its grant is treated as a new request in the next cycle; the scheduler does not pulse-detect.

Decomposition:
- Reuse existing module inc16 (modules/inc16.v) as the single sub-module, instantiated once.
- Shared header modules/inc16_sched_defs.vh holds CH0=0, CH1=1, NCH=2 and W=16.
- No other sub-modules. Arbiter and pointer logic are written inline.

Test Plan:
- Reset: reset=1 for 2 cycles with req=11 and load=11 -> cnt0=cnt1=0000, ovf=00, ptr=0, gnt=00 throughout.
- Contention: req=11 held for 4 cycles from reset -> gnt sequence 01,10,01,10; final cnt0=0002, cnt1=0002; ptr alternates 1,0,1,0.
- Single requester: req=01 for 3 cycles -> gnt=01 each cycle, cnt0=0003, cnt1=0000, ptr=1 after the first grant.
- Wrap: load_val1=FFFE with load[1] for one cycle, then req=10 for 2 cycles -> cnt1=FFFF then 0000; ovf[1]=1 and stays 1. Then clr_ovf=10 -> ovf=00.
- Load vs. request: cnt0=0005, req=11, load=01, load_val0=1234 -> gnt=10, cnt0=1234, cnt1 increments by 1, ovf[0]=0, ptr=0.
- Set beats clear, plus mid-run reset: cnt0=FFFF, req=01, clr_ovf=01 -> cnt0=0000, ovf[0]=1. Then assert reset with req=11 -> all state returns to reset values at that edge.
